// File: rtl/rsa_pkg.sv
// Shared sizing, counter widths and FSM encodings for the modular-exponentiation operand feeder.
package rsa_pkg;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int K         = 128;
  localparam int N         = 16;
  localparam int W         = 32;
  localparam int GAP_CYC   = 10;
  localparam int TAIL_ZERO = 1;
  localparam int P         = K / W;

  localparam int BEAT_CW = cw(P * N);
  localparam int WORD_CW = cw(N + TAIL_ZERO + 1);
  localparam int GAP_CW  = cw(GAP_CYC + 1);
  localparam int IDX_CW  = cw(N);
  localparam int SUB_CW  = cw(P);

  localparam logic [2:0] ST_LOAD     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_STREAM   = 3'd3;
  localparam logic [2:0] ST_WAIT_RES = 3'd4;

endpackage

// File: rtl/rsa_word_packer.sv
// Packs P host beats (LS beat first) into one K-bit word tagged with its word index.
// Latency: word presented combinationally alongside the P-th beat, same cycle.
// Backpressure: none; caller only pulses beat_vld on accepted beats, clr drops the partial word.
module rsa_word_packer
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_vld,
  input  logic [W-1:0]      beat_dat,
  input  logic              clr,
  output logic              word_vld,
  output logic [IDX_CW-1:0] word_idx,
  output logic [K-1:0]      word_dat
);

  logic [SUB_CW-1:0] sub_q;
  logic [IDX_CW-1:0] idx_q;
  logic [K-1:0]      acc_q;

  always_comb begin
    word_dat = acc_q;
    word_dat[sub_q*W +: W] = beat_dat;
  end

  assign word_vld = beat_vld && !clr && (sub_q == SUB_CW'(P - 1));
  assign word_idx = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
    end else if (clr) begin
      sub_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
    end else if (beat_vld) begin
      if (sub_q == SUB_CW'(P - 1)) begin
        sub_q <= '0;
        idx_q <= idx_q + 1'b1;
        acc_q <= '0;
      end else begin
        sub_q <= sub_q + 1'b1;
        acc_q <= word_dat;
      end
    end
  end

endmodule

// File: rtl/me_operand_feeder.sv
// Buffers one K*N-bit operand from the host stream, starts the core and streams the words LSW-first.
// Latency: last beat at t -> me_start t+1, first me_x_valid t+2+GAP_CYC, last valid t+1+GAP_CYC+N+TAIL_ZERO.
// Backpressure: s_ready is low from the final beat until the core has returned all N result words.
module me_operand_feeder
  import rsa_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic         me_start,
  output logic [K-1:0] me_x,
  output logic         me_x_valid,
  input  logic         me_valid,
  output logic         busy,
  output logic         done,
  output logic         frame_err
);

  logic [2:0]          state_q;
  logic [BEAT_CW-1:0]  beat_q;
  logic [GAP_CW-1:0]   gap_q;
  logic [WORD_CW-1:0]  word_q;
  logic [WORD_CW-1:0]  res_q;
  logic [K-1:0]        word_mem [N];

  logic                beat_acc;
  logic                at_end;
  logic                bad;
  logic                pk_vld;
  logic [IDX_CW-1:0]   pk_idx;
  logic [K-1:0]        pk_dat;

  assign s_ready  = (state_q == ST_LOAD);
  assign busy     = !s_ready;
  assign me_start = (state_q == ST_START);
  assign beat_acc = s_valid && s_ready;
  assign at_end   = (beat_q == BEAT_CW'(P * N - 1));
  // s_last must coincide exactly with the final beat; anything else aborts the frame.
  assign bad      = beat_acc && (s_last != at_end);

  rsa_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat_vld (beat_acc),
    .beat_dat (s_data),
    .clr      (bad),
    .word_vld (pk_vld),
    .word_idx (pk_idx),
    .word_dat (pk_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) word_mem[i] <= '0;
    end else if (pk_vld) begin
      word_mem[pk_idx] <= pk_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      beat_q     <= '0;
      gap_q      <= '0;
      word_q     <= '0;
      res_q      <= '0;
      me_x       <= '0;
      me_x_valid <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (beat_acc) begin
            if (bad) begin
              frame_err <= 1'b1;
              beat_q    <= '0;
            end else if (at_end) begin
              beat_q  <= '0;
              state_q <= ST_START;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        ST_START: begin
          gap_q   <= '0;
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          // Word 0 is loaded on the last gap cycle so the stream starts with a registered output.
          if (gap_q == GAP_CW'(GAP_CYC - 1)) begin
            me_x       <= word_mem[0];
            me_x_valid <= 1'b1;
            word_q     <= WORD_CW'(1);
            state_q    <= ST_STREAM;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_STREAM: begin
          if (word_q == WORD_CW'(N + TAIL_ZERO)) begin
            me_x       <= '0;
            me_x_valid <= 1'b0;
            word_q     <= '0;
            res_q      <= '0;
            state_q    <= ST_WAIT_RES;
          end else begin
            me_x   <= (word_q < WORD_CW'(N)) ? word_mem[word_q[IDX_CW-1:0]] : '0;
            word_q <= word_q + 1'b1;
          end
        end
        ST_WAIT_RES: begin
          if (me_valid) begin
            if (res_q == WORD_CW'(N - 1)) begin
              done    <= 1'b1;
              res_q   <= '0;
              state_q <= ST_LOAD;
            end else begin
              res_q <= res_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_me_operand_feeder.sv
// Bench for me_operand_feeder: table of frame scenarios, scoreboard on the me_x stream, reset-in-stream sequence.
module tb_me_operand_feeder;
  import rsa_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         me_start;
  logic [K-1:0] me_x;
  logic         me_x_valid;
  logic         me_valid;
  logic         busy;
  logic         done;
  logic         frame_err;

  me_operand_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .me_start   (me_start),
    .me_x       (me_x),
    .me_x_valid (me_x_valid),
    .me_valid   (me_valid),
    .busy       (busy),
    .done       (done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endfunction

  logic [K-1:0] exp_q[$];
  int   n_start, n_ferr, n_done, n_vld;
  int   start_cyc, first_cyc, done_cyc;
  logic done_busy, done_rdy;
  logic prev_vld = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (me_start) begin n_start++; start_cyc = cyc; end
      if (frame_err) n_ferr++;
      if (done) begin
        n_done++; done_cyc = cyc; done_busy = busy; done_rdy = s_ready;
      end
      if (me_x_valid) begin
        if (!prev_vld) first_cyc = cyc;
        n_vld++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_extra_word: got %h want no valid beat", me_x);
        end else begin
          chk("me_x", me_x, exp_q.pop_front());
        end
      end else begin
        chk("me_x_idle", me_x, '0);
      end
      prev_vld = me_x_valid;
    end
  end

  typedef struct {
    int last_at;    // beat carrying s_last, -1 for none
    bit rnd;        // random s_valid gaps plus garbage while busy
    bit t1;         // fixed top/bottom markers in the operand
    bit exp_err;
    bit pre_valid;  // me_valid driven while START/GAP/STREAM
    int gap_at;     // result beat index preceded by a me_valid gap, -1 none
    int gap_len;
  } vec_t;

  vec_t vecs[7];

  task automatic send_frame(input logic [K*N-1:0] op, input int last_at, input bit rnd,
                            output int acc_c);
    int nb;
    nb = (last_at >= 0 && last_at < P*N-1) ? last_at + 1 : P*N;
    acc_c = 0;
    for (int b = 0; b < nb; b++) begin
      if (rnd) begin
        for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
          s_valid = 1'b0; s_data = $urandom; s_last = 1'b1;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = op[b*W +: W];
      s_last  = (b == last_at);
      begin
        bit ok = 1'b0;
        int g = 0;
        while (!ok && g < 100) begin
          @(negedge clk); ok = s_ready; acc_c = cyc;
          @(posedge clk); #1; g++;
        end
        if (!ok) chk("beat_accept_timeout", K'(ok), K'(1));
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic core_results(input int gap_at, input int gap_len, output int last_c);
    last_c = 0;
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        me_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
        chk("no_done_in_gap", K'(n_done), K'(0));
      end
      me_valid = 1'b1; last_c = cyc;
      @(posedge clk); #1;
    end
    me_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [K*N-1:0] op;
    int acc_c, last_c, g;
    for (int w = 0; w < P*N; w++) op[w*W +: W] = $urandom;
    if (v.t1) begin op[15:0] = 16'hb118; op[K*N-1 -: 16] = 16'h22b9; end
    n_start = 0; n_ferr = 0; n_done = 0; n_vld = 0;
    if (!v.exp_err)
      for (int w = 0; w < N + TAIL_ZERO; w++) exp_q.push_back(w < N ? op[w*K +: K] : '0);
    send_frame(op, v.last_at, v.rnd, acc_c);
    if (v.exp_err) begin
      repeat (GAP_CYC + 5) begin @(posedge clk); #1; end
      chk("frame_err_pulses", K'(n_ferr), K'(1));
      chk("no_start_on_err", K'(n_start), K'(0));
      chk("no_stream_on_err", K'(n_vld), K'(0));
      chk("ready_after_err", K'(s_ready), K'(1));
      return;
    end
    g = 0;
    while (!(n_vld == N + TAIL_ZERO && !me_x_valid) && g < 300) begin
      if (v.rnd) begin
        s_valid = 1'($urandom_range(0, 1)); s_data = $urandom; s_last = 1'($urandom_range(0, 1));
      end
      me_valid = v.pre_valid && (g < 20);
      @(posedge clk); #1; g++;
    end
    s_valid = 1'b0; s_last = 1'b0; me_valid = 1'b0;
    chk("stream_in_time", K'(g < 300), K'(1));
    chk("start_pulses", K'(n_start), K'(1));
    chk("start_latency", K'(start_cyc), K'(acc_c + 1));
    chk("first_valid_latency", K'(first_cyc), K'(acc_c + 2 + GAP_CYC));
    chk("stream_beats", K'(n_vld), K'(N + TAIL_ZERO));
    chk("busy_wait_res", K'(busy), K'(1));
    chk("no_early_done", K'(n_done), K'(0));
    core_results(v.gap_at, v.gap_len, last_c);
    repeat (3) begin @(posedge clk); #1; end
    chk("done_pulses", K'(n_done), K'(1));
    chk("done_latency", K'(done_cyc), K'(last_c + 1));
    chk("busy_at_done", K'(done_busy), K'(0));
    chk("ready_at_done", K'(done_rdy), K'(1));
    chk("no_frame_err", K'(n_ferr), K'(0));
  endtask

  initial begin
    logic [K*N-1:0] op;
    int acc_c, g;
    vec_t clean;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; me_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", K'(s_ready), K'(1));
    chk("rst_busy", K'(busy), K'(0));
    chk("rst_me_start", K'(me_start), K'(0));
    chk("rst_me_x", me_x, '0);
    chk("rst_me_x_valid", K'(me_x_valid), K'(0));
    chk("rst_done", K'(done), K'(0));
    chk("rst_frame_err", K'(frame_err), K'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{63, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0};
    vecs[1] = '{20, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0};
    vecs[2] = '{63, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0};
    vecs[3] = '{-1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0};
    vecs[4] = '{63, 1'b1, 1'b0, 1'b0, 1'b0,  8, 3};
    vecs[5] = '{ 0, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0};
    vecs[6] = '{63, 1'b1, 1'b0, 1'b0, 1'b1,  4, 1};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while word 7 of the stream is on me_x.
    for (int w = 0; w < P*N; w++) op[w*W +: W] = $urandom;
    n_vld = 0;
    for (int w = 0; w < N + TAIL_ZERO; w++) exp_q.push_back(w < N ? op[w*K +: K] : '0);
    send_frame(op, 63, 1'b0, acc_c);
    g = 0;
    while (n_vld < 7 && g < 200) begin @(posedge clk); g++; end
    #2;
    chk("pre_rst_word7", me_x, op[7*K +: K]);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_me_x", me_x, '0);
    chk("arst_me_x_valid", K'(me_x_valid), K'(0));
    chk("arst_busy", K'(busy), K'(0));
    chk("arst_s_ready", K'(s_ready), K'(1));
    chk("arst_me_start", K'(me_start), K'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", K'(s_ready), K'(1));
    clean = '{63, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0};
    run_vec(clean);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
